switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
Multi-channel switch conditioner that sits directly upstream of the LED toggle logic. Each raw push-button input passes through a synchroniser and a stability counter. The block drives a clean debounced level plus single-cycle press and release strobes. The toggle stage consumes o_Release in place of its own raw edge detect.

Parameters:
NUM_SWITCHES, 4, number of independent switch channels.
DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before the output changes (10 ms at 25 MHz); legal range >= 1.
SYNC_STAGES, 2, synchroniser flop depth per channel; legal range >= 2.

Ports:
i_Clk  input  1  system clock.
i_Reset  input  1  asynchronous, active-high reset.
i_Switch  input  NUM_SWITCHES  raw asynchronous switch levels, 1 = pressed.
o_Switch  output  NUM_SWITCHES  debounced level per channel.
o_Press  output  NUM_SWITCHES  one-cycle strobe on a debounced 0->1 transition.
o_Release  output  NUM_SWITCHES  one-cycle strobe on a debounced 1->0 transition.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While i_Reset=1, these are all held at 0 immediately, independent of i_Clk:
  - synchroniser flops
  - counters
  - o_Switch, o_Press, o_Release
- Reset mid-count discards progress. Reset while o_Switch=1 produces no o_Release.
- Synchroniser: SYNC_STAGES-deep flop chain per channel; s_sync is the last stage. Nothing else samples i_Switch.
- Per-channel counter:
  - Width is clog2(DEBOUNCE_LIMIT+1).
  - If s_sync == o_Switch, the counter clears to 0.
  - Otherwise the counter increments.
  - On the clock edge where the incremented value would equal DEBOUNCE_LIMIT, o_Switch takes s_sync and the counter clears.
  - The counter never exceeds DEBOUNCE_LIMIT-1 and never wraps.
- Any cycle where s_sync returns to o_Switch restarts the count. Glitches shorter than DEBOUNCE_LIMIT cycles at s_sync are fully rejected.
- Latency: a raw step held stable changes o_Switch exactly SYNC_STAGES+DEBOUNCE_LIMIT rising edges after the first edge that samples the new value.
- Strobes:
  - o_Press / o_Release are registered and asserted for exactly one cycle.
  - They coincide with the first cycle o_Switch shows its new value.
  - o_Press and o_Release are never both high on one channel.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobe in the same cycle.
- Power-up with a switch already held: after reset deasserts, the channel counts normally and emits o_Press after the full latency. This is intended.
- DEBOUNCE_LIMIT=1 degenerates to synchroniser plus edge detect, with latency SYNC_STAGES+1.
- No combinational path from any input to any output.

Decomposition:
- Shared package switch_pkg holds:
  - DEFAULT_DEBOUNCE_LIMIT (250000)
  - DEFAULT_SYNC_STAGES (2)
  - NUM_BOARD_SWITCHES (4)
- Top-level defaults reference the package constants.
- One sub-module, debounce_channel:
  - Contains one synchroniser, one counter, and the level/strobe registers.
  - Parameterised by DEBOUNCE_LIMIT and SYNC_STAGES.
  - Instantiated NUM_SWITCHES times via generate.
- The top level contains only the generate loop and port bit-slicing.

Test Plan:
All scenarios use DEBOUNCE_LIMIT=4, SYNC_STAGES=2.
- Clean press: i_Switch[0] 0->1 and held. o_Switch[0] rises 6 edges after the first sampling edge; o_Press[0] is high for exactly that one cycle; other channels stay 0.
- Bounce rejection: i_Switch[1] pulses high for 3 cycles, low for 1, high for 3, then low. o_Switch[1], o_Press[1] and o_Release[1] stay 0 throughout.
- Release after bounce: with o_Switch[2]=1, i_Switch[2] toggles 1,0,1,0 on successive cycles, then holds 0. o_Release[2] fires once, 6 edges after the final 1->0 sample; no o_Press[2] occurs.
- Simultaneous channels: i_Switch=4'b1111 in one cycle. o_Switch becomes 4'b1111 and o_Press=4'b1111 in the same cycle, 6 edges later.
- Async reset mid-operation:
  - With o_Switch[3]=1, assert i_Reset between clock edges. o_Switch[3] drops to 0 before the next edge, with no o_Release.
  - Deassert i_Reset with i_Switch[3] held 1. o_Press[3] fires 6 edges after the first post-reset edge.
  - Separately, assert i_Reset while a channel's counter is at 3. The count restarts from 0.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// switch_pkg: board-level constants shared by the switch conditioner files.
//   DEFAULT_DEBOUNCE_LIMIT : stable cycles before a level change (10 ms at 25 MHz)
//   DEFAULT_SYNC_STAGES    : synchroniser depth per channel
//   NUM_BOARD_SWITCHES     : push-buttons fitted on the board
package switch_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250000;
    localparam int unsigned DEFAULT_SYNC_STAGES    = 2;
    localparam int unsigned NUM_BOARD_SWITCHES     = 4;

endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch inputs and conditioned outputs of the debouncer.
//   i_Switch  : raw asynchronous levels, 1 = pressed
//   o_Switch  : debounced level per channel
//   o_Press   : one-cycle strobe on a debounced 0->1 transition
//   o_Release : one-cycle strobe on a debounced 1->0 transition
// Modports: master drives the raw switches, slave is the debouncer.
interface switch_debounce_if
    import switch_pkg::*;
#(
    parameter int unsigned NUM_SWITCHES = NUM_BOARD_SWITCHES
);

    logic [NUM_SWITCHES-1:0] i_Switch;
    logic [NUM_SWITCHES-1:0] o_Switch;
    logic [NUM_SWITCHES-1:0] o_Press;
    logic [NUM_SWITCHES-1:0] o_Release;

    modport master (
        output i_Switch,
        input  o_Switch,
        input  o_Press,
        input  o_Release
    );

    modport slave (
        input  i_Switch,
        output o_Switch,
        output o_Press,
        output o_Release
    );

endinterface

// File: rtl/switch_debounce_channel.sv
// debounce_channel: one switch channel (synchroniser, stability counter, level and strobes).
//   i_Clk     : system clock
//   i_Reset   : asynchronous active-high reset
//   i_Switch  : raw asynchronous switch level
//   o_Switch  : debounced level
//   o_Press   : one-cycle strobe, first cycle o_Switch shows 1
//   o_Release : one-cycle strobe, first cycle o_Switch shows 0
module debounce_channel
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    // Count value on which the next mismatching cycle completes the debounce window.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       count_q;
    logic                   s_sync;

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q    <= '0;
            count_q   <= '0;
            o_Switch  <= 1'b0;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_Switch};
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            if (s_sync == o_Switch) begin
                // Any agreement restarts the window, which is what rejects glitches.
                count_q <= '0;
            end else if (count_q == LAST_CNT) begin
                count_q   <= '0;
                o_Switch  <= s_sync;
                o_Press   <= s_sync;
                o_Release <= ~s_sync;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: multi-channel push-button conditioner feeding the LED toggle logic.
//   i_Clk   : system clock
//   i_Reset : asynchronous active-high reset
//   sw      : switch_debounce_if.slave (i_Switch in; o_Switch, o_Press, o_Release out)
// Each channel is an independent debounce_channel; this level only slices the buses.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int unsigned NUM_SWITCHES   = NUM_BOARD_SWITCHES,
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    switch_debounce_if.slave     sw
);

    logic [NUM_SWITCHES-1:0] level;
    logic [NUM_SWITCHES-1:0] press;
    logic [NUM_SWITCHES-1:0] release_s;

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .i_Clk     (i_Clk),
            .i_Reset   (i_Reset),
            .i_Switch  (sw.i_Switch[g]),
            .o_Switch  (level[g]),
            .o_Press   (press[g]),
            .o_Release (release_s[g])
        );
    end

    assign sw.o_Switch  = level;
    assign sw.o_Press   = press;
    assign sw.o_Release = release_s;

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce with DEBOUNCE_LIMIT=4, SYNC_STAGES=2.
// Reference model: a sliding window over the raw samples; the level flips when the
// LIMIT samples that have cleared the synchroniser all disagree with the current level.
module tb_switch_debounce;

    localparam int NCH  = 4;
    localparam int LIM  = 4;
    localparam int SYNC = 2;
    localparam int HL   = LIM + SYNC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_debounce_if #(.NUM_SWITCHES(NCH)) sw_if ();

    switch_debounce #(
        .NUM_SWITCHES   (NCH),
        .DEBOUNCE_LIMIT (LIM),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .sw      (sw_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: per channel, the last HL raw samples (oldest at index 0).
    bit hist    [NCH][HL];
    bit m_lvl   [NCH];
    bit m_press [NCH];
    bit m_rel   [NCH];

    typedef struct {
        logic [NCH-1:0] in;
        logic [NCH-1:0] e_sw;
        logic [NCH-1:0] e_pr;
        logic [NCH-1:0] e_rl;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3*NCH-1:0] outs();
        return {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release};
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < HL; i++) hist[c][i] = 1'b0;
            m_lvl[c]   = 1'b0;
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic [NCH-1:0] smp);
        for (int c = 0; c < NCH; c++) begin
            bit all_diff;
            for (int i = 0; i < HL - 1; i++) hist[c][i] = hist[c][i+1];
            hist[c][HL-1] = smp[c];
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            all_diff = 1'b1;
            for (int i = 0; i < LIM; i++) if (hist[c][i] == m_lvl[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[c]   = ~m_lvl[c];
                m_press[c] = m_lvl[c];
                m_rel[c]   = ~m_lvl[c];
            end
        end
    endfunction

    function automatic logic [3*NCH-1:0] model_outs();
        logic [NCH-1:0] s, p, r;
        for (int c = 0; c < NCH; c++) begin
            s[c] = m_lvl[c];
            p[c] = m_press[c];
            r[c] = m_rel[c];
        end
        return {s, p, r};
    endfunction

    // One rising edge: advance the model with the value the DUT sampled, then compare.
    task automatic tick();
        logic [NCH-1:0] smp;
        logic           r;
        smp = sw_if.i_Switch;
        r   = rst;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_edge(smp);
        check("model", 32'(outs()), 32'(model_outs()));
        check("press_release_exclusive", 32'(sw_if.o_Press & sw_if.o_Release), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges, check the immediate clear, optionally release it again.
    task automatic async_reset_pulse(input bit release_now);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_clear", 32'(outs()), 32'd0);
        if (release_now) begin
            #2;
            rst = 1'b0;
        end
    endtask

    initial begin
        int press_at, rel_at, n_press, n_rel;

        for (int i = 0; i < 15; i++) begin
            tbl[i].in   = (i < 8) ? 4'b0001 : 4'b0000;
            tbl[i].e_sw = (i >= 5 && i <= 12) ? 4'b0001 : 4'b0000;
            tbl[i].e_pr = (i == 5) ? 4'b0001 : 4'b0000;
            tbl[i].e_rl = (i == 13) ? 4'b0001 : 4'b0000;
        end

        sw_if.i_Switch = '0;
        model_reset();
        idle(2);
        check("reset_state", 32'(outs()), 32'd0);
        rst = 1'b0;
        idle(3);
        check("idle_after_reset", 32'(outs()), 32'd0);

        // Clean press then release on channel 0.
        for (int i = 0; i < 15; i++) begin
            sw_if.i_Switch = tbl[i].in;
            tick();
            check($sformatf("table[%0d]", i), 32'(outs()),
                  32'({tbl[i].e_sw, tbl[i].e_pr, tbl[i].e_rl}));
        end
        idle(3);

        // Bounce rejection on channel 1: 3 high, 1 low, 3 high, then low.
        for (int i = 0; i < 17; i++) begin
            sw_if.i_Switch = (i < 3 || (i >= 4 && i < 7)) ? 4'b0010 : 4'b0000;
            tick();
            check("bounce_quiet",
                  32'({sw_if.o_Switch[1], sw_if.o_Press[1], sw_if.o_Release[1]}), 32'd0);
        end

        // Release after bounce on channel 2.
        sw_if.i_Switch = 4'b0100;
        idle(8);
        check("ch2_level_high", 32'(sw_if.o_Switch[2]), 32'd1);
        n_press = 0;
        n_rel   = 0;
        rel_at  = -1;
        sw_if.i_Switch = 4'b0100; tick(); n_press += int'(sw_if.o_Press[2]);
        sw_if.i_Switch = 4'b0000; tick(); n_press += int'(sw_if.o_Press[2]);
        sw_if.i_Switch = 4'b0100; tick(); n_press += int'(sw_if.o_Press[2]);
        sw_if.i_Switch = 4'b0000;
        for (int j = 1; j <= 10; j++) begin
            tick();
            n_press += int'(sw_if.o_Press[2]);
            if (sw_if.o_Release[2]) begin
                n_rel++;
                rel_at = j;
            end
        end
        check("ch2_release_count", 32'(n_rel), 32'd1);
        check("ch2_release_edge", 32'(rel_at), 32'd6);
        check("ch2_no_press", 32'(n_press), 32'd0);
        idle(3);

        // All channels pressed together.
        sw_if.i_Switch = 4'b1111;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j == 5) check("simul_before", 32'(sw_if.o_Switch), 32'd0);
            if (j == 6) check("simul_edge", 32'({sw_if.o_Switch, sw_if.o_Press}), 32'hFF);
        end
        sw_if.i_Switch = 4'b0000;
        idle(10);

        // Async reset while channel 3 is high, deassert with the switch still held.
        sw_if.i_Switch = 4'b1000;
        idle(8);
        check("ch3_level_high", 32'(sw_if.o_Switch[3]), 32'd1);
        async_reset_pulse(1'b0);
        idle(2);
        #2;
        rst = 1'b0;
        press_at = -1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (sw_if.o_Press[3] && press_at < 0) press_at = j;
            if (sw_if.o_Release[3]) check("ch3_no_release", 32'd1, 32'd0);
        end
        check("ch3_press_after_reset", 32'(press_at), 32'd6);
        sw_if.i_Switch = 4'b0000;
        idle(10);

        // Reset with channel 0 counter at 3: progress must be discarded.
        sw_if.i_Switch = 4'b0001;
        idle(5);
        async_reset_pulse(1'b1);
        press_at = -1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (sw_if.o_Press[0] && press_at < 0) press_at = j;
        end
        check("count_restart", 32'(press_at), 32'd6);
        sw_if.i_Switch = 4'b0000;
        idle(10);

        // Randomised traffic with occasional async resets.
        for (int i = 0; i < 2000; i++) begin
            logic [NCH-1:0] nxt;
            nxt = sw_if.i_Switch;
            for (int c = 0; c < NCH; c++) if ($urandom_range(5) == 0) nxt[c] = ~nxt[c];
            sw_if.i_Switch = nxt;
            if ($urandom_range(299) == 0) async_reset_pulse(1'b1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
